// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - UART transmitter with input FIFO, baud divider, parity and stop-bit options
// Buffered words are framed and shifted out LSB-first, back-to-back while the FIFO has data.
`timescale 1ns/1ps
module uart_tx_fifo #(
   parameter int DATA_BITS    = 8,
   parameter int CLKS_PER_BIT = 16,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1,
   parameter int FIFO_DEPTH   = 8
) (
   input  logic                             clk,
   input  logic                             reset_n,
   input  logic                             wr_enable,
   input  logic [DATA_BITS-1:0]             tx_data,
   output logic                             tx_full,
   output logic                             tx_empty,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count,
   output logic                             tx_overflow,
   output logic                             tx_out,
   output logic                             tx_busy
);
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int CNT_W  = $clog2(FIFO_DEPTH+1);
   localparam int BAUD_W = $clog2(CLKS_PER_BIT);
   localparam int BIT_W  = $clog2(DATA_BITS+1);

   typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

   state_t               state, state_nxt;
   logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]     wr_ptr, rd_ptr;
   logic [CNT_W-1:0]     count_nxt;
   logic [BAUD_W-1:0]    baud, baud_nxt;
   logic [BIT_W-1:0]     bit_cnt, bit_nxt;
   logic [DATA_BITS-1:0] shift, shift_nxt, head;
   logic                 par_bit, par_nxt;
   logic                 push, pop, bit_end;
   logic                 tx_out_nxt, tx_busy_nxt;

   assign push      = wr_enable && !tx_full;
   assign head      = mem[rd_ptr];
   assign bit_end   = (baud == BAUD_W'(CLKS_PER_BIT-1));
   assign count_nxt = fifo_count + CNT_W'(push) - CNT_W'(pop);

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= tx_data;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         fifo_count  <= '0;
         tx_full     <= 1'b0;
         tx_empty    <= 1'b1;
         tx_overflow <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         fifo_count  <= count_nxt;
         tx_full     <= (count_nxt == CNT_W'(FIFO_DEPTH));
         tx_empty    <= (count_nxt == '0);
         // Registered full flag: a write in a full cycle is dropped even if a pop frees a slot.
         tx_overflow <= wr_enable && tx_full;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         baud    <= '0;
         bit_cnt <= '0;
         shift   <= '0;
         par_bit <= 1'b0;
         tx_out  <= 1'b1;
         tx_busy <= 1'b0;
      end else begin
         state   <= state_nxt;
         baud    <= baud_nxt;
         bit_cnt <= bit_nxt;
         shift   <= shift_nxt;
         par_bit <= par_nxt;
         tx_out  <= tx_out_nxt;
         tx_busy <= tx_busy_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      baud_nxt    = bit_end ? '0 : baud + BAUD_W'(1);
      bit_nxt     = bit_cnt;
      shift_nxt   = shift;
      par_nxt     = par_bit;
      pop         = 1'b0;
      tx_out_nxt  = 1'b1;
      tx_busy_nxt = 1'b0;
      case (state)
         IDLE: begin
            baud_nxt = '0;
            if (!tx_empty) begin
               pop       = 1'b1;
               state_nxt = START;
            end
         end
         START: begin
            if (bit_end) begin
               state_nxt = DATA;
               bit_nxt   = '0;
            end
         end
         DATA: begin
            if (bit_end) begin
               shift_nxt = shift >> 1;
               if (bit_cnt == BIT_W'(DATA_BITS-1)) begin
                  state_nxt = (PARITY != 0) ? PAR : STOP;
                  bit_nxt   = '0;
               end else begin
                  bit_nxt = bit_cnt + BIT_W'(1);
               end
            end
         end
         PAR: begin
            if (bit_end) begin
               state_nxt = STOP;
               bit_nxt   = '0;
            end
         end
         STOP: begin
            if (bit_end) begin
               if (bit_cnt == BIT_W'(STOP_BITS-1)) begin
                  bit_nxt = '0;
                  if (!tx_empty) begin
                     pop       = 1'b1;
                     state_nxt = START;
                  end else begin
                     state_nxt = IDLE;
                  end
               end else begin
                  bit_nxt = bit_cnt + BIT_W'(1);
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
      // Parity is fixed at load time so the shifting register need not be preserved.
      if (pop) begin
         shift_nxt = head;
         par_nxt   = (^head) ^ (PARITY == 1);
      end
      case (state_nxt)
         START:   tx_out_nxt = 1'b0;
         DATA:    tx_out_nxt = shift_nxt[0];
         PAR:     tx_out_nxt = par_nxt;
         default: tx_out_nxt = 1'b1;
      endcase
      tx_busy_nxt = (state_nxt != IDLE);
   end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - self-checking bench for uart_tx_fifo
// u0 (8E2, 4 clk/bit, depth 4) is checked every cycle against a frame-level model; u1..u3 use literal waveforms.
`timescale 1ns/1ps
module tb_uart_tx_fifo;
   localparam int M_CPB = 4;
   localparam int M_DEP = 4;
   localparam int M_FL  = (1 + 8 + 1 + 2) * M_CPB;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic wr0 = 1'b0, wr1 = 1'b0, wr2 = 1'b0, wr3 = 1'b0;
   logic [7:0] d0 = '0, d1 = '0, d2 = '0;
   logic [4:0] d3 = '0;
   logic u0_full, u0_empty, u0_ovf, u0_out, u0_busy;
   logic u1_full, u1_empty, u1_ovf, u1_out, u1_busy;
   logic u2_full, u2_empty, u2_ovf, u2_out, u2_busy;
   logic u3_full, u3_empty, u3_ovf, u3_out, u3_busy;
   logic [2:0] u0_cnt;
   logic [3:0] u1_cnt, u2_cnt, u3_cnt;
   wire  [3:0] out_v   = {u3_out, u2_out, u1_out, u0_out};
   wire  [3:0] busy_v  = {u3_busy, u2_busy, u1_busy, u0_busy};
   wire  [3:0] empty_v = {u3_empty, u2_empty, u1_empty, u0_empty};

   int n_chk = 0, n_fail = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   uart_tx_fifo #(.DATA_BITS(8), .CLKS_PER_BIT(M_CPB), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(M_DEP)) u0 (
      .clk(clk), .reset_n(reset_n), .wr_enable(wr0), .tx_data(d0), .tx_full(u0_full), .tx_empty(u0_empty),
      .fifo_count(u0_cnt), .tx_overflow(u0_ovf), .tx_out(u0_out), .tx_busy(u0_busy));
   uart_tx_fifo #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(8)) u1 (
      .clk(clk), .reset_n(reset_n), .wr_enable(wr1), .tx_data(d1), .tx_full(u1_full), .tx_empty(u1_empty),
      .fifo_count(u1_cnt), .tx_overflow(u1_ovf), .tx_out(u1_out), .tx_busy(u1_busy));
   uart_tx_fifo #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(8)) u2 (
      .clk(clk), .reset_n(reset_n), .wr_enable(wr2), .tx_data(d2), .tx_full(u2_full), .tx_empty(u2_empty),
      .fifo_count(u2_cnt), .tx_overflow(u2_ovf), .tx_out(u2_out), .tx_busy(u2_busy));
   uart_tx_fifo #(.DATA_BITS(5), .CLKS_PER_BIT(2), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(8)) u3 (
      .clk(clk), .reset_n(reset_n), .wr_enable(wr3), .tx_data(d3), .tx_full(u3_full), .tx_empty(u3_empty),
      .fifo_count(u3_cnt), .tx_overflow(u3_ovf), .tx_out(u3_out), .tx_busy(u3_busy));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      n_chk++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp_v);
      end
   endtask

   // Line value for each bit slot of a frame: start, payload LSB first, optional parity, then stop ones.
   function automatic logic [15:0] frame_bits(input int db, input int par, input logic [8:0] d);
      logic [15:0] b;
      logic p;
      b = '1;
      b[0] = 1'b0;
      p = 1'b0;
      for (int i = 0; i < db; i++) begin
         b[i+1] = d[i];
         p = p ^ d[i];
      end
      if (par != 0) b[db+1] = (par == 1) ? ~p : p;
      return b;
   endfunction

   logic [7:0]  mq[$];
   int          t = -1;
   logic [15:0] fbits = '1;
   logic        exp_ovf = 1'b0;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mq.delete();
         t = -1;
         exp_ovf = 1'b0;
      end else begin
         int n;
         n = mq.size();
         exp_ovf = wr0 && (n == M_DEP);
         if (t == M_FL - 1) t = -1;
         else if (t >= 0) t++;
         if (t == -1 && n > 0) begin
            fbits = frame_bits(8, 2, {1'b0, mq.pop_front()});
            t = 0;
         end
         if (wr0 && n < M_DEP) mq.push_back(d0);
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("u0_tx_out", 32'(u0_out), 32'((t < 0) ? 1'b1 : fbits[t / M_CPB]));
         chk("u0_tx_busy", 32'(u0_busy), 32'(t >= 0));
         chk("u0_fifo_count", 32'(u0_cnt), 32'(mq.size()));
         chk("u0_tx_full", 32'(u0_full), 32'(mq.size() == M_DEP));
         chk("u0_tx_empty", 32'(u0_empty), 32'(mq.size() == 0));
         chk("u0_tx_overflow", 32'(u0_ovf), 32'(exp_ovf));
      end
   end

   int   b0_cyc = 0, b0_rise = 0, ovf_n = 0;
   logic b0_prev = 1'b0;
   always @(negedge clk) begin
      if (u0_busy === 1'b1) b0_cyc++;
      if (u0_busy === 1'b1 && b0_prev !== 1'b1) b0_rise++;
      if (u0_ovf === 1'b1) ovf_n++;
      b0_prev = u0_busy;
   end

   task automatic write(input int w, input logic [7:0] d);
      @(negedge clk);
      case (w)
         0: begin wr0 = 1'b1; d0 = d; end
         1: begin wr1 = 1'b1; d1 = d; end
         2: begin wr2 = 1'b1; d2 = d; end
         default: begin wr3 = 1'b1; d3 = d[4:0]; end
      endcase
      @(negedge clk);
      wr0 = 1'b0; wr1 = 1'b0; wr2 = 1'b0; wr3 = 1'b0;
   endtask

   task automatic play(input int w, input string name, input logic [15:0] bits, input int nslots, input int cpb);
      for (int c = 0; c < nslots * cpb; c++) begin
         @(negedge clk);
         chk({name, "_out"}, 32'(out_v[w]), 32'(bits[c / cpb]));
         chk({name, "_busy"}, 32'(busy_v[w]), 32'd1);
      end
      @(negedge clk);
      chk({name, "_end_busy"}, 32'(busy_v[w]), 32'd0);
      chk({name, "_end_out"}, 32'(out_v[w]), 32'd1);
   endtask

   task automatic wait_idle(input int w);
      bit done;
      done = 1'b0;
      for (int k = 0; k < 2000 && !done; k++) begin
         @(negedge clk);
         if (busy_v[w] === 1'b0 && empty_v[w] === 1'b1) done = 1'b1;
      end
      chk("idle_wait", 32'(done), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int base, rbase, obase;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      chk_en  = 1'b1;
      chk("rst_tx_out", 32'(u0_out), 32'd1);
      chk("rst_tx_busy", 32'(u0_busy), 32'd0);
      chk("rst_tx_empty", 32'(u0_empty), 32'd1);
      chk("rst_tx_full", 32'(u0_full), 32'd0);
      chk("rst_fifo_count", 32'(u0_cnt), 32'd0);

      write(1, 8'hA5);
      play(1, "n81_a5", 16'b0000001101001010, 10, 4);
      write(2, 8'hA5);
      play(2, "o81_a5", 16'b0000011101001010, 11, 4);
      write(3, 8'hFF);
      play(3, "n51_1f", 16'b0000000001111110, 7, 2);

      write(0, 8'hA5);
      repeat (37) @(negedge clk);
      chk("e82_par_a5", 32'(u0_out), 32'd0);
      wait_idle(0);
      write(0, 8'h07);
      repeat (37) @(negedge clk);
      chk("e82_par_07", 32'(u0_out), 32'd1);
      wait_idle(0);

      base = b0_cyc; rbase = b0_rise;
      @(negedge clk); wr0 = 1'b1; d0 = 8'h00;
      @(negedge clk); d0 = 8'hFF;
      @(negedge clk); d0 = 8'h3C;
      @(negedge clk); wr0 = 1'b0;
      wait_idle(0);
      chk("b2b_busy_cycles", 32'(b0_cyc - base), 32'(3 * 48));
      chk("b2b_busy_rises", 32'(b0_rise - rbase), 32'd1);

      base = b0_cyc; rbase = b0_rise; obase = ovf_n;
      write(0, 8'h80);
      repeat (3) @(negedge clk);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         wr0 = 1'b1;
         d0 = 8'(8'h11 * (i + 1));
      end
      @(negedge clk);
      wr0 = 1'b0;
      chk("ovf_fifo_count", 32'(u0_cnt), 32'd4);
      chk("ovf_tx_full", 32'(u0_full), 32'd1);
      wait_idle(0);
      chk("ovf_pulses", 32'(ovf_n - obase), 32'd2);
      chk("ovf_busy_cycles", 32'(b0_cyc - base), 32'(5 * 48));
      chk("ovf_busy_rises", 32'(b0_rise - rbase), 32'd1);

      write(0, 8'h5A);
      repeat (15) @(negedge clk);
      @(posedge clk);
      #3 reset_n = 1'b0;
      #1;
      chk("arst_tx_out", 32'(u0_out), 32'd1);
      chk("arst_tx_busy", 32'(u0_busy), 32'd0);
      chk("arst_tx_empty", 32'(u0_empty), 32'd1);
      chk("arst_fifo_count", 32'(u0_cnt), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      base = b0_cyc;
      write(0, 8'hC3);
      wait_idle(0);
      chk("arst_next_frame_cycles", 32'(b0_cyc - base), 32'd48);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
